// File: rtl/tron_match_scoreboard.sv
// rtl/tron_match_scoreboard.sv - Tron round/match scoreboard: crash latching, round award, match decision
module tron_match_scoreboard #(
  parameter int         NUM_PLAYERS   = 2,
  parameter int         WIN_SCORE     = 3,
  parameter int         SCORE_W       = 2,
  parameter logic [7:0] ALIVE_COLOR   = 8'h01,
  parameter int         SETTLE_CYCLES = 4
) (
  input  logic                           Clk,
  input  logic                           Reset_Score,
  input  logic [2:0]                     Game_State,
  input  logic [8*NUM_PLAYERS-1:0]       player_color,
  output logic [SCORE_W*NUM_PLAYERS-1:0] score,
  output logic                           reset_round,
  output logic                           round_draw,
  output logic [NUM_PLAYERS-1:0]         winner,
  output logic                           match_over,
  output logic [7:0]                     round_count
);
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    PLAY, SETTLE, AWARD, ROUND_RESET, WAIT_CLEAR, MATCH_OVER
  } state_t;

  state_t                           state;
  logic [NUM_PLAYERS-1:0]           crash_q;
  logic [NUM_PLAYERS-1:0]           crashed;
  logic [NUM_PLAYERS-1:0]           survivors;
  logic [NUM_PLAYERS-1:0]           win_hit;
  logic [CNT_W-1:0]                 settle_cnt;
  logic                             quiet;
  logic [3:0]                       alive;
  logic [SCORE_W*NUM_PLAYERS-1:0]   score_upd;
  logic                             clear;
  logic                             latch_en;

  assign clear    = Reset_Score | (Game_State == 3'd0);
  assign latch_en = (state == PLAY) || (state == SETTLE);

  // The crash arriving this cycle counts immediately, so the round closes one cycle after crash_q rises.
  always_comb begin
    survivors = ~(crashed | (latch_en ? crash_q : '0));
    alive     = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      alive = alive + 4'(survivors[i]);
    end
  end

  always_comb begin
    score_upd = score;
    win_hit   = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (alive == 4'd1 && survivors[i] && score[SCORE_W*i +: SCORE_W] < WIN) begin
        score_upd[SCORE_W*i +: SCORE_W] = score[SCORE_W*i +: SCORE_W] + SCORE_W'(1);
      end
      win_hit[i] = (score_upd[SCORE_W*i +: SCORE_W] == WIN);
    end
  end

  always_ff @(posedge Clk) begin
    if (clear) begin
      state       <= PLAY;
      crash_q     <= '0;
      crashed     <= '0;
      settle_cnt  <= '0;
      quiet       <= 1'b0;
      score       <= '0;
      reset_round <= 1'b0;
      round_draw  <= 1'b0;
      winner      <= '0;
      match_over  <= 1'b0;
      round_count <= '0;
    end else begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        crash_q[i] <= (player_color[8*i +: 8] != ALIVE_COLOR);
      end
      reset_round <= 1'b0;
      round_draw  <= 1'b0;
      if (latch_en) begin
        crashed <= crashed | crash_q;
      end
      case (state)
        PLAY: begin
          if (alive <= 4'd1) begin
            state      <= SETTLE;
            settle_cnt <= '0;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + CNT_W'(1);
          if (settle_cnt == CNT_LAST) begin
            state      <= AWARD;
            round_draw <= (alive == 4'd0);
          end
        end
        AWARD: begin
          score       <= score_upd;
          round_count <= round_count + 8'd1;
          if (|win_hit) begin
            state      <= MATCH_OVER;
            match_over <= 1'b1;
            winner     <= win_hit;
          end else begin
            state       <= ROUND_RESET;
            reset_round <= 1'b1;
          end
        end
        ROUND_RESET: begin
          crashed <= '0;
          quiet   <= 1'b0;
          state   <= WAIT_CLEAR;
        end
        // Two quiet samples in a row mean the renderer has wiped the old trails.
        WAIT_CLEAR: begin
          if (|crash_q) begin
            quiet <= 1'b0;
          end else if (quiet) begin
            state <= PLAY;
          end else begin
            quiet <= 1'b1;
          end
        end
        MATCH_OVER: ;
        default: state <= PLAY;
      endcase
    end
  end
endmodule
